timer_sequencer: RTL and testbench

//   Top-level sequencer for the programmable stopwatch/timer counter datapath. Takes debounced button levels,

---
 rtl/timer_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_timer_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sequencer.sv
// timer_sequencer
//   Control sequencer for the stopwatch/timer BCD counter datapath. It turns
//   debounced button levels into single-cycle presses, handles per-digit
//   preset programming, selects up or down counting, gates the datapath count
//   enable, and raises a timed alarm when a countdown expires.
//
// Ports
//   clk              in   1      system clock, rising edge
//   resetN           in   1      asynchronous active-low reset
//   startStopButton  in   1      debounced level: start / pause / resume
//   setButton        in   1      debounced level: enter programming / next digit
//   incButton        in   1      debounced level: increment selected digit
//   modeButton       in   1      debounced level: toggle up/down (IDLE only)
//   countZero        in   1      datapath count == 0
//   clear            out  1      datapath synchronous clear
//   cnt              out  1      datapath count enable
//   countDown        out  1      0 = count up, 1 = count down
//   digitSel         out  DIG_W  digit being programmed
//   digitInc         out  1      one-cycle increment pulse for digitSel
//   alarm            out  1      expiry alarm
//   stateOut         out  3      current state encoding
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | 000  datapath held clear; mode may be toggled
// PROG    | 001  programming preset, one digit at a time
// READY   | 010  preset loaded, waiting for start
// RUN     | 011  counting
// PAUSE   | 100  count held
// EXPIRED | 101  countdown hit zero, alarm asserted for ALARM_CYCLES

module timer_sequencer #(
    parameter int  NUM_DIGITS   = 4,
    parameter int  ALARM_CYCLES = 1000,
    localparam int DIG_W        = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startStopButton,
    input  logic             setButton,
    input  logic             incButton,
    input  logic             modeButton,
    input  logic             countZero,
    output logic             clear,
    output logic             cnt,
    output logic             countDown,
    output logic [DIG_W-1:0] digitSel,
    output logic             digitInc,
    output logic             alarm,
    output logic [2:0]       stateOut
);

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_PROG    = 3'b001;
    localparam logic [2:0] S_READY   = 3'b010;
    localparam logic [2:0] S_RUN     = 3'b011;
    localparam logic [2:0] S_PAUSE   = 3'b100;
    localparam logic [2:0] S_EXPIRED = 3'b101;

    localparam int               ALM_W    = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [ALM_W-1:0] ALM_LAST = ALM_W'(ALARM_CYCLES - 1);
    localparam logic [DIG_W-1:0] SEL_LAST = DIG_W'(NUM_DIGITS - 1);

    logic [2:0]       r_state;
    logic             r_count_down;
    logic [DIG_W-1:0] r_digit_sel;
    logic             r_digit_inc;
    logic [ALM_W-1:0] r_alarm_cnt;
    logic             r_prev_ss;
    logic             r_prev_set;
    logic             r_prev_inc;
    logic             r_prev_mode;

    logic             w_ss_raw, w_set_raw, w_inc_raw, w_mode_raw;
    logic             w_ss_p, w_set_p, w_inc_p, w_mode_p, w_any_p;
    logic             w_zero_dn;
    logic [2:0]       w_state_nxt;
    logic             w_count_down_nxt;
    logic [DIG_W-1:0] w_digit_sel_nxt;
    logic             w_digit_inc_nxt;
    logic [ALM_W-1:0] w_alarm_cnt_nxt;

    // History regs reset to 1 so a button held through reset is not a press.
    assign w_ss_raw   = startStopButton & ~r_prev_ss;
    assign w_set_raw  = setButton       & ~r_prev_set;
    assign w_inc_raw  = incButton       & ~r_prev_inc;
    assign w_mode_raw = modeButton      & ~r_prev_mode;

    // Only the highest-priority press of a cycle survives.
    assign w_ss_p   = w_ss_raw;
    assign w_set_p  = w_set_raw  & ~w_ss_raw;
    assign w_inc_p  = w_inc_raw  & ~w_ss_raw & ~w_set_raw;
    assign w_mode_p = w_mode_raw & ~w_ss_raw & ~w_set_raw & ~w_inc_raw;
    assign w_any_p  = w_ss_raw | w_set_raw | w_inc_raw | w_mode_raw;

    assign w_zero_dn = r_count_down & countZero;

    always_comb begin
        w_state_nxt      = r_state;
        w_count_down_nxt = r_count_down;
        w_digit_sel_nxt  = r_digit_sel;
        w_digit_inc_nxt  = 1'b0;
        w_alarm_cnt_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_ss_p) begin
                    // A countdown from a cleared preset has nothing to count.
                    if (!r_count_down) w_state_nxt = S_RUN;
                end else if (w_set_p) begin
                    w_state_nxt     = S_PROG;
                    w_digit_sel_nxt = '0;
                end else if (w_mode_p) begin
                    w_count_down_nxt = ~r_count_down;
                end
            end
            S_PROG: begin
                if (w_ss_p) begin
                    w_state_nxt     = S_READY;
                    w_digit_sel_nxt = '0;
                end else if (w_set_p) begin
                    if (r_digit_sel == SEL_LAST) begin
                        w_state_nxt     = S_READY;
                        w_digit_sel_nxt = '0;
                    end else begin
                        w_digit_sel_nxt = r_digit_sel + 1'b1;
                    end
                end else if (w_inc_p) begin
                    w_digit_inc_nxt = 1'b1;
                end
            end
            S_READY: begin
                if (w_ss_p) begin
                    w_state_nxt = w_zero_dn ? S_EXPIRED : S_RUN;
                end else if (w_set_p) begin
                    w_state_nxt     = S_PROG;
                    w_digit_sel_nxt = '0;
                end
            end
            S_RUN: begin
                if (w_zero_dn)   w_state_nxt = S_EXPIRED;
                else if (w_ss_p) w_state_nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (w_ss_p) w_state_nxt = S_RUN;
            end
            S_EXPIRED: begin
                if (w_any_p || (r_alarm_cnt == ALM_LAST)) w_state_nxt = S_IDLE;
                else                                      w_alarm_cnt_nxt = r_alarm_cnt + 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_IDLE;
            r_count_down <= 1'b0;
            r_digit_sel  <= '0;
            r_digit_inc  <= 1'b0;
            r_alarm_cnt  <= '0;
            r_prev_ss    <= 1'b1;
            r_prev_set   <= 1'b1;
            r_prev_inc   <= 1'b1;
            r_prev_mode  <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_count_down <= w_count_down_nxt;
            r_digit_sel  <= w_digit_sel_nxt;
            r_digit_inc  <= w_digit_inc_nxt;
            r_alarm_cnt  <= w_alarm_cnt_nxt;
            r_prev_ss    <= startStopButton;
            r_prev_set   <= setButton;
            r_prev_inc   <= incButton;
            r_prev_mode  <= modeButton;
        end
    end

    assign clear     = (r_state == S_IDLE);
    // Gated combinationally so the datapath never steps below zero.
    assign cnt       = (r_state == S_RUN) & ~w_zero_dn;
    assign alarm     = (r_state == S_EXPIRED);
    assign countDown = r_count_down;
    assign digitSel  = r_digit_sel;
    assign digitInc  = r_digit_inc;
    assign stateOut  = r_state;

endmodule

// File: tb/tb_timer_sequencer.sv
module tb_timer_sequencer;

    localparam int ND = 4;
    localparam int AC = 8;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startStopButton = 1'b0;
    logic       setButton = 1'b0;
    logic       incButton = 1'b0;
    logic       modeButton = 1'b0;
    logic       countZero = 1'b0;
    logic       clear, cnt, countDown, digitInc, alarm;
    logic [1:0] digitSel;
    logic [2:0] stateOut;

    timer_sequencer #(.NUM_DIGITS(ND), .ALARM_CYCLES(AC)) dut (
        .clk(clk), .resetN(resetN),
        .startStopButton(startStopButton), .setButton(setButton),
        .incButton(incButton), .modeButton(modeButton), .countZero(countZero),
        .clear(clear), .cnt(cnt), .countDown(countDown), .digitSel(digitSel),
        .digitInc(digitInc), .alarm(alarm), .stateOut(stateOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_val(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0d, expected nothing queued", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === 32'(e.val)) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0 startStop, 1 set, 2 inc, 3 mode: hold for one edge, then release for one edge.
    task automatic press(input int b);
        case (b)
            0: startStopButton = 1'b1;
            1: setButton = 1'b1;
            2: incButton = 1'b1;
            default: modeButton = 1'b1;
        endcase
        tick();
        startStopButton = 1'b0;
        setButton = 1'b0;
        incButton = 1'b0;
        modeButton = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        tick();
    endtask

    initial begin
        int n;

        // Reset with startStop held high.
        startStopButton = 1'b1;
        #1;
        expect_val("rst_clear", 1);  compare(32'(clear));
        expect_val("rst_state", 0);  compare(32'(stateOut));
        tick(); tick();
        expect_val("rst_cnt", 0);    compare(32'(cnt));
        expect_val("rst_alarm", 0);  compare(32'(alarm));
        expect_val("rst_clear2", 1); compare(32'(clear));
        resetN = 1'b1;
        expect_val("held_no_start", 0);
        tick(); tick();
        compare(32'(stateOut));
        startStopButton = 1'b0;
        expect_val("release_idle", 0);
        tick();
        compare(32'(stateOut));

        // Up mode: run, pause, run.
        expect_val("up_run_state", 3);
        expect_val("up_run_cnt", 1);
        press(0);
        compare(32'(stateOut));
        compare(32'(cnt));
        expect_val("up_pause_state", 4);
        expect_val("up_pause_cnt", 0);
        press(0);
        compare(32'(stateOut));
        compare(32'(cnt));
        expect_val("up_resume_state", 3);
        press(0);
        compare(32'(stateOut));

        // Programming four digits.
        do_reset();
        expect_val("prog_state", 1);
        expect_val("prog_sel0", 0);
        press(1);
        compare(32'(stateOut));
        compare(32'(digitSel));
        for (int i = 0; i < 3; i++) begin
            expect_val("inc_pulse", 1);
            expect_val("inc_sel", 0);
            expect_val("inc_pulse_end", 0);
            incButton = 1'b1;
            tick();
            compare(32'(digitInc));
            compare(32'(digitSel));
            incButton = 1'b0;
            tick();
            compare(32'(digitInc));
        end
        for (int i = 1; i < ND; i++) begin
            expect_val("sel_step", i);
            press(1);
            compare(32'(digitSel));
        end
        expect_val("ready_state", 2);
        expect_val("ready_sel", 0);
        press(1);
        compare(32'(stateOut));
        compare(32'(digitSel));

        // Countdown to expiry with full-length alarm.
        do_reset();
        expect_val("mode_toggle", 1);
        press(3);
        compare(32'(countDown));
        press(1);
        press(2);
        expect_val("cd_ready", 2);
        press(0);
        compare(32'(stateOut));
        expect_val("cd_run", 3);
        expect_val("cd_run_cnt", 1);
        press(0);
        compare(32'(stateOut));
        compare(32'(cnt));
        countZero = 1'b1;
        expect_val("cd_gate_cnt", 0);
        expect_val("cd_gate_state", 3);
        #1;
        compare(32'(cnt));
        compare(32'(stateOut));
        expect_val("cd_expired", 5);
        expect_val("alarm_cycles", AC);
        expect_val("after_alarm_state", 0);
        expect_val("countdown_kept", 1);
        tick();
        compare(32'(stateOut));
        n = 0;
        while (alarm === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        compare(32'(n));
        compare(32'(stateOut));
        compare(32'(countDown));

        // RUN: countZero and startStop on the same edge -> EXPIRED.
        press(1);
        countZero = 1'b0;
        press(0);
        expect_val("sim_run", 3);
        press(0);
        compare(32'(stateOut));
        expect_val("sim_expired", 5);
        countZero = 1'b1;
        startStopButton = 1'b1;
        tick();
        compare(32'(stateOut));
        startStopButton = 1'b0;
        tick();
        expect_val("early_exit", 0);
        setButton = 1'b1;
        tick();
        compare(32'(stateOut));
        setButton = 1'b0;
        tick();

        // PROG: set and inc together -> advance only.
        press(1);
        expect_val("set_inc_sel", 1);
        expect_val("set_inc_noinc", 0);
        expect_val("set_inc_noinc2", 0);
        setButton = 1'b1;
        incButton = 1'b1;
        tick();
        compare(32'(digitSel));
        compare(32'(digitInc));
        setButton = 1'b0;
        incButton = 1'b0;
        tick();
        compare(32'(digitInc));

        // Reset during a digitInc pulse.
        expect_val("pulse_before_rst", 1);
        expect_val("rst_pulse_inc", 0);
        expect_val("rst_pulse_state", 0);
        expect_val("rst_pulse_clear", 1);
        expect_val("rst_pulse_cd", 0);
        incButton = 1'b1;
        tick();
        compare(32'(digitInc));
        resetN = 1'b0;
        #1;
        compare(32'(digitInc));
        compare(32'(stateOut));
        compare(32'(clear));
        compare(32'(countDown));
        incButton = 1'b0;
        tick();
        resetN = 1'b1;
        tick();

        // Countdown start in IDLE is ignored; READY with zero goes straight to EXPIRED.
        countZero = 1'b0;
        press(3);
        expect_val("idle_cd_start", 0);
        press(0);
        compare(32'(stateOut));
        press(1);
        press(0);
        countZero = 1'b1;
        expect_val("ready_zero_expired", 5);
        expect_val("ready_zero_alarm", 1);
        press(0);
        compare(32'(stateOut));
        compare(32'(alarm));
        expect_val("rst_exp_alarm", 0);
        expect_val("rst_exp_state", 0);
        expect_val("rst_exp_cd", 0);
        resetN = 1'b0;
        #1;
        compare(32'(alarm));
        compare(32'(stateOut));
        compare(32'(countDown));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
